// File: rtl/uart_tx_if.sv
// Upstream byte handshake for the UART transmitter.
// The producer drives data/valid; the transmitter answers with ready.
// A byte moves on any clk edge where valid and ready are both high.
interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, STOP_BITS stop bits.
// Bit timing comes from a clock-enable counter running on clk; there are no derived clocks.
// Bytes arrive over the uart_tx_if valid/ready handshake.
// The optional even-parity slot is enabled by defining UART_TX_PARITY_EN.
// When that macro is undefined, the PARITY state and all parity logic are left out.
// STOP_BITS may be 1 or 2. CLOCK_FREQ/BAUD_RATE must be at least 2.
module uart_tx #(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 38400000,
    parameter int STOP_BITS  = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  up,
    output logic      tx,
    output logic      busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int STOP_W       = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [STOP_W-1:0]  stop_q, stop_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               accept;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    assign accept   = up.valid && ready_q;
    assign up.ready = ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

    // Next-state logic. The outputs are computed from the next state so that every output comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        stop_d    = stop_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d   = up.data;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^up.data;
`endif
                    bit_idx_d = 3'd0;
                    baud_d    = '0;
                    stop_d    = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        stop_d  = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    stop_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (stop_q == STOP_LAST) begin
                    stop_d  = '0;
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    stop_d = stop_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = !ready_d;
    end

    // State and output registers. A synchronous reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            stop_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            stop_q    <= stop_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT = 10.
// dut1 has one stop bit and dut2 has two. Both share clk and rst.
// When UART_TX_PARITY_EN is defined, the expected frames include an even-parity slot.
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_SLOTS = 1;
`else
    localparam int PAR_SLOTS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx1, busy1, tx2, busy2;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_if bus1 ();
    uart_tx_if bus2 ();

    uart_tx #(.BAUD_RATE(9600), .CLOCK_FREQ(96000), .STOP_BITS(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .up   (bus1),
        .tx   (tx1),
        .busy (busy1)
    );

    uart_tx #(.BAUD_RATE(9600), .CLOCK_FREQ(96000), .STOP_BITS(2)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .up   (bus2),
        .tx   (tx2),
        .busy (busy2)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Advances one clock. The bench then sits 1 time unit after the edge, where it drives and samples.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            bus2.valid = v;
            bus2.data  = d;
        end else begin
            bus1.valid = v;
            bus1.data  = d;
        end
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Expected line level for one bit slot of a frame carrying byte b.
    function automatic logic expectedTx(input logic [7:0] b, input int slot);
        if (slot == 0)
            return 1'b0;
        if (slot <= 8)
            return b[slot-1];
        if (PAR_SLOTS == 1 && slot == 9)
            return ^b;
        return 1'b1;
    endfunction

    // Called in cycle 1 after the accept edge. It checks tx and ready on every cycle of the frame.
    // It returns in the first cycle where ready is high again.
    // If injectAt > 0, a one-cycle valid pulse carrying 0x3C is driven at that cycle.
    task automatic checkFrame(input bit sel, input logic [7:0] b, input int stopBits,
                              input int injectAt, input string name);
        int total;
        total = (9 + PAR_SLOTS + stopBits) * CPB;
        for (int k = 1; k <= total; k++) begin
            if (injectAt > 0 && k == injectAt)
                applyStimulus(sel, 1'b1, 8'h3C);
            else if (injectAt > 0 && k == injectAt + 1)
                applyStimulus(sel, 1'b0, 8'h3C);
            checkOutput($sformatf("%s tx c%0d", name, k), sel ? tx2 : tx1, expectedTx(b, (k - 1) / CPB));
            checkOutput($sformatf("%s ready c%0d", name, k), sel ? bus2.ready : bus1.ready, 1'b0);
            if (k == 1)
                checkOutput($sformatf("%s busy c1", name), sel ? busy2 : busy1, 1'b1);
            tick();
        end
        checkOutput($sformatf("%s ready end", name), sel ? bus2.ready : bus1.ready, 1'b1);
        checkOutput($sformatf("%s tx end", name), sel ? tx2 : tx1, 1'b1);
        checkOutput($sformatf("%s busy end", name), sel ? busy2 : busy1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("reset tx1", tx1, 1'b1);
        checkOutput("reset ready1", bus1.ready, 1'b1);
        checkOutput("reset busy1", busy1, 1'b0);
        checkOutput("reset tx2", tx2, 1'b1);
        checkOutput("reset ready2", bus2.ready, 1'b1);
        checkOutput("reset busy2", busy2, 1'b0);
        rst = 1'b0;
        tick();

        // Single 0xA5 frame. data changes right after the accept edge and must be ignored.
        applyStimulus(1'b0, 1'b1, 8'hA5);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkFrame(1'b0, 8'hA5, 1, 0, "a5");

        // valid held high: 0x00, then 0xFF, separated by exactly one idle cycle.
        applyStimulus(1'b0, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checkFrame(1'b0, 8'h00, 1, 0, "b2b00");
        tick();
        applyStimulus(1'b0, 1'b0, 8'hFF);
        checkFrame(1'b0, 8'hFF, 1, 0, "b2bFF");

        // 0x3C offered while busy must be dropped, not queued.
        applyStimulus(1'b0, 1'b1, 8'h55);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h55);
        checkFrame(1'b0, 8'h55, 1, 30, "busy55");
        tick();
        checkOutput("noqueue ready", bus1.ready, 1'b1);
        checkOutput("noqueue tx", tx1, 1'b1);

        // Reset 45 cycles into a 0x81 frame, then send a clean 0x81 frame.
        applyStimulus(1'b0, 1'b1, 8'h81);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h81);
        repeat (44) tick();
        checkOutput("prerst tx", tx1, 1'b0);
        checkOutput("prerst busy", busy1, 1'b1);
        rst = 1'b1;
        tick();
        checkOutput("abort tx", tx1, 1'b1);
        checkOutput("abort ready", bus1.ready, 1'b1);
        checkOutput("abort busy", busy1, 1'b0);
        rst = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b1, 8'h81);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h81);
        checkFrame(1'b0, 8'h81, 1, 0, "post81");

        // Two stop bits on dut2.
        applyStimulus(1'b1, 1'b1, 8'h0F);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h0F);
        checkFrame(1'b1, 8'h0F, 2, 0, "stop2");

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 has three ones, 0x03 has two.
        applyStimulus(1'b0, 1'b1, 8'h07);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h07);
        checkFrame(1'b0, 8'h07, 1, 0, "par07");
        applyStimulus(1'b0, 1'b1, 8'h03);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h03);
        checkFrame(1'b0, 8'h03, 1, 0, "par03");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter. Serialises one byte per frame onto `tx`: 1 start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1).
- Pairs with the existing UART receiver on the same link and shares its BAUD_RATE/CLOCK_FREQ parameter scheme.
- Bit timing comes from an internal clock-enable counter. No derived clocks.
- Upstream logic hands bytes in over a valid/ready handshake.

Parameters:
- BAUD_RATE, 9600, line bit rate in bits/s.
- CLOCK_FREQ, 38400000, `clk` frequency in Hz.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- Derived (localparam): CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, integer division. Must be >= 2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- data  input  8  byte to send; sampled only on the accept cycle.
- valid  input  1  upstream has a byte on `data`.
- ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line output; idle level is 1.
- busy  output  1  a frame is in progress (any state other than IDLE).

Behaviour:
- Interface: one clock domain, `clk`; reset `rst` is synchronous and active-high.
- Reset values: tx=1, ready=1, busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame aborts the frame. tx=1 from the next edge and the byte is discarded.
- All outputs are registered. tx has no combinational path from the inputs.
- ready = 1 only in IDLE. busy = !ready.
- Accept: `valid && ready` at a posedge.
  - `data` is latched into the shift register.
  - State goes to START.
  - tx is still 1 during the accept cycle itself.
- valid while not ready: ignored. No queuing, no error.
- Changes on `data` after accept have no effect on the frame in progress.
- State machine (baud counter counts 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT clk cycles):
  - IDLE: tx=1. On accept go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], held for CLKS_PER_BIT cycles.
    - Then shift right by 1 and increment the index.
    - After index 7 completes, go to PARITY (feature enabled) or STOP.
  - PARITY: see Optional Feature.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Frame length from the cycle after accept to the first cycle ready=1 again:
  - (1+8+STOP_BITS)*CLKS_PER_BIT cycles.
  - With the feature enabled: (1+8+1+STOP_BITS)*CLKS_PER_BIT.
- Back-to-back frames:
  - Upstream holding valid=1 is accepted on the first ready=1 cycle.
  - This leaves exactly 1 extra idle (tx=1) cycle between frames.
- Baud counter resets to 0 on every state transition, so no drift accumulates across bits.
- Widths:
  - Baud counter width = $clog2(CLKS_PER_BIT).
  - Stop counter sized for STOP_BITS*CLKS_PER_BIT.
  - Bit index is 3 bits; it wraps 7 -> exit, never to 0 inside DATA.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = even parity (XOR of the 8 latched bits) for CLKS_PER_BIT cycles.
  - Parity is computed from the byte at accept time, not from the shifted register.
- Undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP.

Test Plan (CLOCK_FREQ=96000, BAUD_RATE=9600, so CLKS_PER_BIT=10; STOP_BITS=1 unless noted):
- Single byte 0xA5, valid pulsed 1 cycle in IDLE:
  - ready falls the next cycle; tx sequence per 10-cycle slot is 0,1,0,1,0,0,1,0,1,1.
  - ready=1 again exactly 100 cycles after the accept cycle.
- valid held high with 0x00 then 0xFF:
  - two frames, separated by exactly 1 idle cycle of tx=1.
  - data bits all 0, then all 1.
- valid pulsed with 0x3C while busy, 30 cycles into a frame of 0x55: the 0x3C is ignored; only the 0x55 frame appears; ready stays 0 until that frame ends.
- rst asserted 45 cycles into a frame of 0x81:
  - tx=1, ready=1, busy=0 on the cycle after the reset edge.
  - A new 0x81 accepted afterwards produces a full correct frame.
- STOP_BITS=2, byte 0x0F: stop level held 20 cycles; ready returns at 110 cycles.
- UART_TX_PARITY_EN defined:
  - Byte 0x07 gives a parity slot of tx=1; byte 0x03 gives a parity slot of tx=0.
  - Frame length is 110 cycles.
